bus_terminal: RTL
=================

BUS_TERMINAL -- requirements
Module: bus_terminal

Interface
REQ-001 Parameter pckg_sz, default 16: bus word width; bits [pckg_sz-1:pckg_sz-8] are the destination ID, the remaining bits are payload.
REQ-002 Parameter depth, default 8: entries in each of the TX and RX FIFOs; power of two, at least 2.
REQ-003 Parameter id, default 0: own terminal ID, 8 bits.
REQ-004 Parameter bdcst, default 8'hFF: broadcast ID.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  host request to enqueue wr_data into the TX FIFO.
REQ-008 wr_data  in  pckg_sz  host word to transmit.
REQ-009 tx_full  out  1  TX FIFO holds depth entries.
REQ-010 tx_ovf  out  1  sticky flag: a host write was dropped.
REQ-011 pndng  out  1  TX FIFO not empty; bus-facing.
REQ-012 D_pop  out  pckg_sz  TX FIFO head word; bus-facing.
REQ-013 pop  in  1  bus consumes the head word.
REQ-014 push  in  1  bus delivers D_push this cycle.
REQ-015 D_push  in  pckg_sz  word delivered by the bus.
REQ-016 rd_en  in  1  host request to dequeue from the RX FIFO.
REQ-017 rd_data  out  pckg_sz  registered RX word.
REQ-018 rd_valid  out  1  one-cycle pulse; rd_data is valid.
REQ-019 rx_empty  out  1  RX FIFO holds 0 entries.
REQ-020 drop_cnt  out  8  saturating count of accepted-address words dropped because the RX FIFO was full.
REQ-021 mis_cnt  out  8  saturating count of words dropped on ID mismatch.

Function
REQ-022 The TX FIFO SHALL be first-word fall-through: D_pop equals the head entry combinationally whenever pndng=1, and D_pop equals 0 when the FIFO is empty.
REQ-023 pop with pndng=1 SHALL remove the head; the next entry appears on D_pop in the following cycle.
REQ-024 pop with pndng=0 SHALL be ignored, with no pointer or count change.
REQ-025 wr_en with the TX FIFO not full SHALL enqueue wr_data; pndng rises the cycle after a write into an empty FIFO.
REQ-026 wr_en while full without a same-cycle valid pop SHALL drop the word and set tx_ovf.
REQ-027 wr_en and pop in the same cycle while full SHALL accept both, and the count stays at depth.
REQ-028 wr_en and pop in the same cycle while empty: the write is accepted and the pop is ignored.
REQ-029 A push SHALL be accepted when D_push[pckg_sz-1:pckg_sz-8] equals id or bdcst; otherwise the word is discarded and mis_cnt increments.
REQ-030 An accepted-address push while the RX FIFO is full and no same-cycle read occurs SHALL be discarded and increment drop_cnt.
REQ-031 An accepted-address push with a same-cycle valid read while the RX FIFO is full SHALL be stored.
REQ-032 rd_en while the RX FIFO is not empty SHALL load the head into rd_data and pulse rd_valid in the next cycle (read latency 1).
REQ-033 rd_en while rx_empty=1 SHALL be ignored: rd_valid stays 0 and rd_data holds its value.
REQ-034 A push into an empty RX FIFO SHALL deassert rx_empty in the next cycle; it is not readable in the same cycle.
REQ-035 Pointers SHALL wrap modulo depth; occupancy counters SHALL be log2(depth)+1 bits wide.
REQ-036 drop_cnt and mis_cnt SHALL saturate at 8'hFF and never wrap.
REQ-037 The TX and RX paths SHALL be fully independent; no ordering exists between them.

Reset
REQ-038 When reset=1 at a clock edge, both FIFOs SHALL empty, and outputs SHALL take these values in the next cycle: pndng=0, D_pop=0, tx_full=0, tx_ovf=0, rx_empty=1, rd_valid=0, rd_data=0, drop_cnt=0, mis_cnt=0.
REQ-039 wr_en, pop, push and rd_en SHALL be ignored during any cycle with reset=1.
REQ-040 Reset asserted mid-operation SHALL discard all stored words; no partial state survives.

Verification
REQ-041 Write 16'h0A01, 16'h0A02 and hold pop=0 -> pndng=1 and D_pop=16'h0A01; pop one cycle -> D_pop=16'h0A02; pop again -> pndng=0.
REQ-042 Write 9 words with depth=8 and no pop -> tx_full=1 after the 8th write, tx_ovf=1 after the 9th, and 8 pops return words 1-8 in order.
REQ-043 With id=3, push 16'h0355, 16'hFF66, 16'h0477 -> RX holds 16'h0355 then 16'hFF66, mis_cnt=1, and two rd_en pulses give rd_valid one cycle after each with those words.
REQ-044 Fill RX to 8 entries, then push 300 more own-ID words without reads -> drop_cnt=8'hFF and occupancy stays 8; a same-cycle rd_en+push while full stores the push.
REQ-045 Fill TX to 5 entries, assert reset for one cycle with wr_en=1 -> the next cycle shows pndng=0, tx_ovf=0 and an empty FIFO; a pop is ignored.
REQ-046 Issue rd_en on an empty RX and pop on an empty TX -> rd_valid=0 and there is no counter or pointer change.

Source files
------------

// File: rtl/bus_terminal.sv
// Bus terminal: host-facing TX FIFO (first-word fall-through toward the bus) and an
// address-filtered RX FIFO with a registered, one-cycle-latency host read port.
module bus_terminal #(
  parameter int         pckg_sz = 16,
  parameter int         depth   = 8,
  parameter logic [7:0] id      = 8'h00,
  parameter logic [7:0] bdcst   = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               tx_full,
  output logic               tx_ovf,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               rd_en,
  output logic [pckg_sz-1:0] rd_data,
  output logic               rd_valid,
  output logic               rx_empty,
  output logic [7:0]         drop_cnt,
  output logic [7:0]         mis_cnt
);

  localparam int             AW       = $clog2(depth);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(depth);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // TX path state
  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [AW-1:0]      tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW-1:0]      tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW:0]        tx_cnt_q, tx_cnt_d;
  logic               tx_ovf_q, tx_ovf_d;
  logic               tx_wr, tx_rd;

  // RX path state
  logic [pckg_sz-1:0] rx_mem_q [depth];
  logic [AW-1:0]      rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW-1:0]      rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW:0]        rx_cnt_q, rx_cnt_d;
  logic [pckg_sz-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [7:0]         mis_cnt_q, mis_cnt_d;
  logic               rx_match, rx_wr, rx_rd;

  // A pop on an empty FIFO never counts, so a full FIFO only admits a write when the pop is real.
  always_comb begin
    tx_rd       = pop && (tx_cnt_q != '0);
    tx_wr       = wr_en && ((tx_cnt_q != FULL_CNT) || tx_rd);
    tx_wr_ptr_d = tx_wr ? tx_wr_ptr_q + PTR_ONE : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd ? tx_rd_ptr_q + PTR_ONE : tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    case ({tx_wr, tx_rd})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    tx_ovf_d = tx_ovf_q | (wr_en & ~tx_wr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      tx_ovf_q    <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_ovf_q    <= tx_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && tx_wr) tx_mem_q[tx_wr_ptr_q] <= wr_data;
  end

  assign pndng   = (tx_cnt_q != '0);
  assign D_pop   = pndng ? tx_mem_q[tx_rd_ptr_q] : '0;
  assign tx_full = (tx_cnt_q == FULL_CNT);
  assign tx_ovf  = tx_ovf_q;

  // RX: address filter, then the same full/simultaneous-read rule as TX.
  always_comb begin
    rx_match    = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == bdcst);
    rx_rd       = rd_en && (rx_cnt_q != '0);
    rx_wr       = push && rx_match && ((rx_cnt_q != FULL_CNT) || rx_rd);
    rx_wr_ptr_d = rx_wr ? rx_wr_ptr_q + PTR_ONE : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd ? rx_rd_ptr_q + PTR_ONE : rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    case ({rx_wr, rx_rd})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    rd_data_d  = rx_rd ? rx_mem_q[rx_rd_ptr_q] : rd_data_q;
    rd_valid_d = rx_rd;
    drop_cnt_d = (push && rx_match && !rx_wr) ? sat_inc(drop_cnt_q) : drop_cnt_q;
    mis_cnt_d  = (push && !rx_match) ? sat_inc(mis_cnt_q) : mis_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      drop_cnt_q  <= 8'h00;
      mis_cnt_q   <= 8'h00;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      drop_cnt_q  <= drop_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  // When full with a simultaneous read, write and read share a slot; the read sees the old word.
  always_ff @(posedge clk) begin
    if (!reset && rx_wr) rx_mem_q[rx_wr_ptr_q] <= D_push;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rx_empty = (rx_cnt_q == '0);
  assign drop_cnt = drop_cnt_q;
  assign mis_cnt  = mis_cnt_q;

endmodule
